// File: rtl/ps2_letter_fifo_if.sv
// Scan-byte input, letter FIFO handshake and status bundle for ps2_letter_fifo.
// The DUT takes the slave modport; the byte source / letter consumer takes master.
interface ps2_letter_fifo_if #(
   parameter int unsigned DEPTH = 4
);
   logic [7:0]                   scan_code;
   logic                         scan_valid;
   logic [25:0]                  letter;
   logic                         letter_valid;
   logic                         letter_ready;
   logic [$clog2(DEPTH+1)-1:0]   count;
   logic                         overflow;
   logic [7:0]                   last_code;

   modport master (
      output scan_code, scan_valid, letter_ready,
      input  letter, letter_valid, count, overflow, last_code
   );

   modport slave (
      input  scan_code, scan_valid, letter_ready,
      output letter, letter_valid, count, overflow, last_code
   );
endinterface

// File: rtl/ps2_letter_fifo.sv
// PS/2 Set-2 letter decoder with F0/E0 prefix tracking and a first-word-fall-through FIFO.
// Optional typematic-repeat suppression (make-emission only) via PS2_REPEAT_FILTER_EN.
module ps2_letter_fifo #(
   parameter int unsigned DEPTH         = 4,
   parameter bit          EMIT_ON_BREAK = 1'b1
) (
   input logic              CLOCK_50,
   input logic              resetn,
   ps2_letter_fifo_if.slave bus
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {StIdle, StBrk, StExt, StExtBrk} state_e;

   state_e          state_q, state_d;
   logic [25:0]     code_onehot;
   logic            is_letter;
   logic            push_req, push, pop, full, not_empty;
   logic [25:0]     mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q;
   logic            overflow_q;
   logic [7:0]      last_code_q;
`ifdef PS2_REPEAT_FILTER_EN
   logic [7:0]      held_q, held_d;
`endif

   always_comb begin
      code_onehot = '0;
      case (bus.scan_code)
         8'h1C: code_onehot[0]  = 1'b1;
         8'h32: code_onehot[1]  = 1'b1;
         8'h21: code_onehot[2]  = 1'b1;
         8'h23: code_onehot[3]  = 1'b1;
         8'h24: code_onehot[4]  = 1'b1;
         8'h2B: code_onehot[5]  = 1'b1;
         8'h34: code_onehot[6]  = 1'b1;
         8'h33: code_onehot[7]  = 1'b1;
         8'h43: code_onehot[8]  = 1'b1;
         8'h3B: code_onehot[9]  = 1'b1;
         8'h42: code_onehot[10] = 1'b1;
         8'h4B: code_onehot[11] = 1'b1;
         8'h3A: code_onehot[12] = 1'b1;
         8'h31: code_onehot[13] = 1'b1;
         8'h44: code_onehot[14] = 1'b1;
         8'h4D: code_onehot[15] = 1'b1;
         8'h15: code_onehot[16] = 1'b1;
         8'h2D: code_onehot[17] = 1'b1;
         8'h1B: code_onehot[18] = 1'b1;
         8'h2C: code_onehot[19] = 1'b1;
         8'h3C: code_onehot[20] = 1'b1;
         8'h2A: code_onehot[21] = 1'b1;
         8'h1D: code_onehot[22] = 1'b1;
         8'h22: code_onehot[23] = 1'b1;
         8'h35: code_onehot[24] = 1'b1;
         8'h1A: code_onehot[25] = 1'b1;
         default: code_onehot = '0;
      endcase
   end

   assign is_letter = |code_onehot;

   // Prefix FSM: state register
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) state_q <= StIdle;
      else         state_q <= state_d;
   end

   // Prefix FSM: next state; F0 keeps the extended flag if one is pending
   always_comb begin
      state_d = state_q;
      if (bus.scan_valid) begin
         if (bus.scan_code == 8'hE0) begin
            state_d = StExt;
         end else if (bus.scan_code == 8'hF0) begin
            state_d = (state_q == StExt || state_q == StExtBrk) ? StExtBrk : StBrk;
         end else begin
            state_d = StIdle;
         end
      end
   end

   // Prefix FSM: emission decision
   always_comb begin
      push_req = 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
      held_d   = held_q;
`endif
      if (bus.scan_valid && is_letter) begin
         unique case (state_q)
            StIdle:  push_req = !EMIT_ON_BREAK;
            StBrk:   push_req = EMIT_ON_BREAK;
            default: push_req = 1'b0;
         endcase
`ifdef PS2_REPEAT_FILTER_EN
         if (!EMIT_ON_BREAK) begin
            if (state_q == StIdle) begin
               if (bus.scan_code == held_q) push_req = 1'b0;
               else                         held_d   = bus.scan_code;
            end else if (state_q == StBrk && bus.scan_code == held_q) begin
               held_d = '0;
            end
         end
`endif
      end
   end

`ifdef PS2_REPEAT_FILTER_EN
   // 8'h00 is never a letter, so it doubles as "nothing held"
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) held_q <= '0;
      else         held_q <= held_d;
   end
`endif

   assign not_empty = (count_q != '0);
   assign full      = (count_q == CW'(DEPTH));
   assign pop       = not_empty && bus.letter_ready;
   // A simultaneous pop frees the slot, so a full FIFO still accepts
   assign push      = push_req && (!full || pop);

   always_ff @(posedge CLOCK_50) begin
      if (push) mem_q[wr_ptr_q] <= code_onehot;
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         last_code_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !push) count_q <= count_q - 1'b1;
         if (push_req && full && !pop) overflow_q <= 1'b1;
         if (bus.scan_valid) last_code_q <= bus.scan_code;
      end
   end

   assign bus.letter_valid = not_empty;
   assign bus.letter       = not_empty ? mem_q[rd_ptr_q] : '0;
   assign bus.count        = count_q;
   assign bus.overflow     = overflow_q;
   assign bus.last_code    = last_code_q;
endmodule

// File: tb/tb_ps2_letter_fifo.sv
// Directed bench: one break-emitting and one make-emitting instance share the byte stream.
module tb_ps2_letter_fifo;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   ps2_letter_fifo_if #(.DEPTH(4)) bus_b ();
   ps2_letter_fifo_if #(.DEPTH(4)) bus_m ();

   ps2_letter_fifo #(.DEPTH(4), .EMIT_ON_BREAK(1'b1)) dut_b (
      .CLOCK_50 (clk),
      .resetn   (resetn),
      .bus      (bus_b)
   );

   ps2_letter_fifo #(.DEPTH(4), .EMIT_ON_BREAK(1'b0)) dut_m (
      .CLOCK_50 (clk),
      .resetn   (resetn),
      .bus      (bus_m)
   );

   typedef struct {
      logic [7:0]  code;
      logic [25:0] exp_letter;
      logic        exp_valid;
   } vec_t;

   vec_t       vec [30];
   logic [7:0] codes [26];
   logic [7:0] others [4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic set_scan(input logic [7:0] c, input logic v);
      bus_b.scan_code  = c;
      bus_m.scan_code  = c;
      bus_b.scan_valid = v;
      bus_m.scan_valid = v;
   endtask

   // Ends #1 after the capturing edge, so results of that edge are visible
   task automatic send(input logic [7:0] c);
      @(posedge clk); #1;
      set_scan(c, 1'b1);
      @(posedge clk); #1;
      set_scan(8'h00, 1'b0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      resetn = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
   endtask

   initial begin
      codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
                8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
                8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
      others = '{8'h00, 8'h29, 8'h5A, 8'h76};
      for (int i = 0; i < 26; i++) vec[i] = '{codes[i], 26'(1) << i, 1'b1};
      for (int i = 0; i < 4; i++)  vec[26 + i] = '{others[i], 26'h0, 1'b0};

      set_scan(8'h00, 1'b0);
      bus_b.letter_ready = 1'b0;
      bus_m.letter_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      chk("rst_letter", 32'(bus_b.letter), 32'h0);
      chk("rst_valid", 32'(bus_b.letter_valid), 32'h0);
      chk("rst_count", 32'(bus_m.count), 32'h0);
      chk("rst_ovf", 32'(bus_m.overflow), 32'h0);
      chk("rst_last", 32'(bus_m.last_code), 32'h0);
      resetn = 1'b1;

      // Make mode, consumer always ready: each make shows next cycle, popped on the following
      bus_m.letter_ready = 1'b1;
      for (int i = 0; i < 30; i++) begin
         send(vec[i].code);
         chk($sformatf("tbl_letter_%0d", i), 32'(bus_m.letter), 32'(vec[i].exp_letter));
         chk($sformatf("tbl_valid_%0d", i), 32'(bus_m.letter_valid), 32'(vec[i].exp_valid));
         chk($sformatf("tbl_last_%0d", i), 32'(bus_m.last_code), 32'(vec[i].code));
         chk($sformatf("tbl_brk_%0d", i), 32'(bus_b.count), 32'h0);
      end
      bus_m.letter_ready = 1'b0;

      // Break mode: 1C F0 1C -> A after release
      do_reset();
      send(8'h1C);
      chk("brk_make_nopush", 32'(bus_b.count), 32'h0);
      send(8'hF0);
      send(8'h1C);
      chk("brk_letter", 32'(bus_b.letter), 32'h1);
      chk("brk_valid", 32'(bus_b.letter_valid), 32'h1);
      chk("brk_count", 32'(bus_b.count), 32'h1);

      // Extended release is ignored; normal Z release follows
      do_reset();
      send(8'hE0); send(8'hF0); send(8'h1C);
      chk("ext_nopush", 32'(bus_b.count), 32'h0);
      send(8'hF0); send(8'h1A);
      chk("ext_then_z", 32'(bus_b.letter), 32'h2000000);

      // Overflow: five makes into a 4-deep FIFO
      do_reset();
      send(8'h32); send(8'h21); send(8'h23); send(8'h24);
      chk("fill_ovf_clear", 32'(bus_m.overflow), 32'h0);
      send(8'h2B);
      chk("ovf_count", 32'(bus_m.count), 32'h4);
      chk("ovf_set", 32'(bus_m.overflow), 32'h1);
      bus_m.letter_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("ovf_pop_%0d", i), 32'(bus_m.letter), 32'h2 << i);
         @(posedge clk); #1;
      end
      bus_m.letter_ready = 1'b0;
      chk("drain_letter", 32'(bus_m.letter), 32'h0);
      chk("drain_valid", 32'(bus_m.letter_valid), 32'h0);
      chk("ovf_sticky", 32'(bus_m.overflow), 32'h1);

      // Full FIFO with a push coincident with a pop
      do_reset();
      send(8'h32); send(8'h21); send(8'h23); send(8'h24);
      @(posedge clk); #1;
      set_scan(8'h2B, 1'b1);
      bus_m.letter_ready = 1'b1;
      @(posedge clk); #1;
      set_scan(8'h00, 1'b0);
      bus_m.letter_ready = 1'b0;
      chk("pp_count", 32'(bus_m.count), 32'h4);
      chk("pp_ovf", 32'(bus_m.overflow), 32'h0);
      bus_m.letter_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("pp_pop_%0d", i), 32'(bus_m.letter), 32'h4 << i);
         @(posedge clk); #1;
      end
      bus_m.letter_ready = 1'b0;
      chk("pp_empty", 32'(bus_m.count), 32'h0);

      // Typematic repeat
      do_reset();
      send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
`ifdef PS2_REPEAT_FILTER_EN
      chk("rep_count", 32'(bus_m.count), 32'h2);
`else
      chk("rep_count", 32'(bus_m.count), 32'h4);
`endif
      chk("rep_head", 32'(bus_m.letter), 32'h1);

      // Reset mid-stream discards a pending F0
      do_reset();
      send(8'hF0);
      do_reset();
      send(8'h1C);
      chk("midrst_count", 32'(bus_b.count), 32'h0);
      chk("midrst_valid", 32'(bus_b.letter_valid), 32'h0);
      chk("midrst_last", 32'(bus_b.last_code), 32'h1C);
      send(8'hF0); send(8'h1C);
      chk("midrst_after", 32'(bus_b.letter), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ps2_letter_fifo.md
# ps2_letter_fifo

Decodes the PS/2 Set-2 byte stream from `keyboard` into one-hot 26-bit letter codes (bit 0 = A … bit 25 = Z) and buffers them in a first-word-fall-through FIFO with a valid/ready handshake. It sits between `keyboard` and the `rero` rotor/reflector path, whose 26-bit one-hot input it drives. It replaces the level-only history decode with four things:

- tracking of the F0 (break) and E0 (extended) prefixes;
- selectable make or break emission;
- buffering of keystrokes;
- overflow reporting.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries, power of two ≥ 2.
- `EMIT_ON_BREAK`, 1: 1 = letter emitted on key release (F0 xx); 0 = letter emitted on make code.

Ports:
- `CLOCK_50`  in  1  system clock; all logic on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `scan_code`  in  8  byte from `keyboard`.
- `scan_valid`  in  1  one-cycle strobe; `scan_code` is valid this cycle.
- `letter`  out  26  one-hot FIFO head; 26'h0 when empty.
- `letter_valid`  out  1  FIFO non-empty.
- `letter_ready`  in  1  consumer accepts head when high with `letter_valid`.
- `count`  out  $clog2(DEPTH+1)  entries held.
- `overflow`  out  1  sticky; set when a decoded letter is dropped because the FIFO is full.
- `last_code`  out  8  last byte accepted on `scan_valid`, for HEX display.

## Operation
- Letter map (make codes): A 1C, B 32, C 21, D 23, E 24, F 2B, G 34, H 33, I 43, J 3B, K 42, L 4B, M 3A, N 31, O 44, P 4D, Q 15, R 2D, S 1B, T 2C, U 3C, V 2A, W 1D, X 22, Y 35, Z 1A. Every other byte is non-letter.
- Prefix FSM states: IDLE, BRK, EXT, EXT_BRK. It advances only on `scan_valid`.
- Transitions from IDLE:
  - E0 → EXT.
  - F0 → BRK.
  - Any other byte → IDLE.
- Transitions from BRK:
  - E0 → EXT.
  - F0 → BRK.
  - Any other byte → IDLE.
- Transitions from EXT:
  - F0 → EXT_BRK.
  - E0 → EXT.
  - Any other byte → IDLE.
- Transitions from EXT_BRK:
  - E0 → EXT.
  - F0 → EXT_BRK.
  - Any other byte → IDLE.
- Emission:
  - `EMIT_ON_BREAK`=1: a letter byte received in BRK pushes its one-hot code. Letter bytes in IDLE push nothing.
  - `EMIT_ON_BREAK`=0: a letter byte received in IDLE pushes. Letter bytes in BRK are consumed silently.
  - Bytes received in EXT or EXT_BRK never push.
- FIFO rules:
  - Push: write to `wr_ptr`, increment `count`.
  - Pop (`letter_valid && letter_ready`): advance `rd_ptr`, decrement `count`.
  - Pointers wrap modulo `DEPTH`.
  - Push and pop in the same cycle: both occur and `count` is unchanged. This applies when full as well; no overflow is raised in that case.
  - Push when full with no pop: the letter is dropped, `overflow` goes high, and FIFO contents are unchanged.
  - `letter_ready` while empty: no effect.
- `overflow` clears only on reset.

## Timing
- Reset values (asynchronous assertion, synchronous release):
  - FSM = IDLE.
  - `wr_ptr` = `rd_ptr` = 0, `count` = 0.
  - `letter` = 26'h0, `letter_valid` = 0.
  - `overflow` = 0, `last_code` = 8'h00.
  - Repeat filter register cleared.
- Latency: with the FIFO empty, the `scan_valid` edge ending cycle n that causes a push drives `letter` and `letter_valid` in cycle n+1.
- `last_code` updates on the same edge as the `scan_valid` it captures.
- Handshake:
  - `letter` holds stable while `letter_valid` is high and not popped.
  - After a pop, the next entry (or 0 when empty) appears in the following cycle.
- Reset mid-stream: a pending F0/E0 prefix is discarded, and the next byte is decoded from IDLE.

## Configuration
- Macro `PS2_REPEAT_FILTER_EN`.
- Defined, with `EMIT_ON_BREAK`=0:
  - A letter make code equal to the last pushed make code is dropped if no break for that key has arrived since. This suppresses typematic repeat.
  - Receiving F0 followed by that key's code clears the held code.
  - Reset also clears it.
- Defined, with `EMIT_ON_BREAK`=1: no effect.
- Not defined: every make code emits, including typematic repeats.

## Test plan
- Reset, then `EMIT_ON_BREAK`=1, bytes 1C, F0, 1C, `letter_ready`=0 → `letter`=26'h1, `letter_valid`=1 one cycle after the final byte, `count`=1.
- Extended key: bytes E0, F0, 1C → no push, `count`=0. Then F0, 1A → `letter`=26'h2000000.
- `EMIT_ON_BREAK`=0, `DEPTH`=4, `letter_ready`=0, makes 32, 21, 23, 24, 2B → `count`=4, `overflow`=1, then pops return in order 26'h2, 26'h4, 26'h8, 26'h10 → `letter`=0 and `letter_valid`=0 after the last pop.
- Full FIFO, a push coincident with `letter_ready`=1 → `count` stays 4, `overflow` unchanged, and the new letter is read after the three older entries.
- With `PS2_REPEAT_FILTER_EN`, `EMIT_ON_BREAK`=0, bytes 1C, 1C, 1C, F0, 1C, 1C → exactly two pushes of 26'h1. Without the macro → four pushes.
- Bytes F0 then `resetn` low for one cycle, then 1C in break mode → no push, FSM IDLE, `last_code`=8'h1C.
